// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cond_pkg
// Purpose  : Condition-code encodings and flag bit positions shared by the
//            condition unit and the branch predictor check.
// Revision : 1.0  initial release
// ============================================================================
package cond_pkg;

    typedef logic [3:0] cond_t;

    localparam cond_t COND_NEVER  = 4'd0;
    localparam cond_t COND_EQ     = 4'd1;
    localparam cond_t COND_LT     = 4'd2;
    localparam cond_t COND_LE     = 4'd3;
    localparam cond_t COND_ALWAYS = 4'd4;
    localparam cond_t COND_NE     = 4'd5;
    localparam cond_t COND_GE     = 4'd6;
    localparam cond_t COND_GT     = 4'd7;
    localparam cond_t COND_VS     = 4'd8;
    localparam cond_t COND_VC     = 4'd9;
    localparam cond_t COND_ULT    = 4'd10;
    localparam cond_t COND_ULE    = 4'd11;
    localparam cond_t COND_MI     = 4'd12;
    localparam cond_t COND_PL     = 4'd13;
    localparam cond_t COND_UGE    = 4'd14;
    localparam cond_t COND_UGT    = 4'd15;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Purpose  : Combinational evaluation of a 4-bit condition code against
//            {V,C,N,Z} flags.
// Revision : 1.0  initial release
// ============================================================================
module cond_eval
    import cond_pkg::*;
(
    input  cond_t      cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic w_z;
    logic w_n;
    logic w_c;
    logic w_v;
    logic w_lt;

    assign w_z  = flags[FLAG_Z];
    assign w_n  = flags[FLAG_N];
    assign w_c  = flags[FLAG_C];
    assign w_v  = flags[FLAG_V];
    // Signed less-than after a compare
    assign w_lt = w_n ^ w_v;

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NEVER:  taken = 1'b0;
            COND_EQ:     taken = w_z;
            COND_LT:     taken = w_lt;
            COND_LE:     taken = w_z | w_lt;
            COND_ALWAYS: taken = 1'b1;
            COND_NE:     taken = ~w_z;
            COND_GE:     taken = ~w_lt;
            COND_GT:     taken = ~w_z & ~w_lt;
            COND_VS:     taken = w_v;
            COND_VC:     taken = ~w_v;
            COND_ULT:    taken = w_c;
            COND_ULE:    taken = w_c | w_z;
            COND_MI:     taken = w_n;
            COND_PL:     taken = ~w_n;
            COND_UGE:    taken = ~w_c;
            COND_UGT:    taken = ~w_c & ~w_z;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_flag_unit
// Purpose  : Flag register plus condition evaluation, delivered through a
//            LATENCY-deep valid/ready result pipeline.
// Revision : 1.0  initial release
// ============================================================================
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1,
    parameter int BYPASS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flags_we,
    input  logic [WIDTH-1:0] alu_value,
    input  logic             alu_carry,
    input  logic             alu_ovf,
    input  logic             cond_valid,
    output logic             cond_ready,
    input  cond_t            cond,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic [3:0]       flags
);

    generate
        if (WIDTH < 2 || LATENCY < 1 || LATENCY > 4) begin : g_param_check
            $error("cond_flag_unit: WIDTH must be >= 2 and LATENCY within 1..4");
        end
    endgenerate

    logic [3:0]         r_flags;
    logic [3:0]         w_new_flags;
    logic [3:0]         w_src_flags;
    logic               w_eval;
    logic               w_advance;
    logic [LATENCY-1:0] r_stage_valid;
    logic [LATENCY-1:0] r_stage_taken;

    assign w_new_flags = {alu_ovf, alu_carry, alu_value[WIDTH-1], ~|alu_value};
    assign w_src_flags = ((BYPASS != 0) && flags_we) ? w_new_flags : r_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 4'b0001;
        end else if (flags_we) begin
            r_flags <= w_new_flags;
        end
    end

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (w_src_flags),
        .taken (w_eval)
    );

    // Global stall: the whole pipe moves or holds together, bubbles included
    assign w_advance = ~r_stage_valid[LATENCY-1] | res_ready;

    generate
        for (genvar k = 0; k < LATENCY; k++) begin : g_stage
            if (k == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_stage_valid[0] <= 1'b0;
                        r_stage_taken[0] <= 1'b0;
                    end else if (w_advance) begin
                        r_stage_valid[0] <= cond_valid;
                        r_stage_taken[0] <= w_eval;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_stage_valid[k] <= 1'b0;
                        r_stage_taken[k] <= 1'b0;
                    end else if (w_advance) begin
                        r_stage_valid[k] <= r_stage_valid[k-1];
                        r_stage_taken[k] <= r_stage_taken[k-1];
                    end
                end
            end
        end
    endgenerate

    assign cond_ready = w_advance;
    assign res_valid  = r_stage_valid[LATENCY-1];
    assign res_taken  = r_stage_taken[LATENCY-1];
    assign flags      = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_flag_unit
// Purpose  : Self-checking bench; a bypassing and a non-bypassing instance
//            share one stimulus stream and are checked against a reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_cond_flag_unit;

    localparam int WIDTH = 8;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flags_we = 1'b0;
    logic [WIDTH-1:0] alu_value = '0;
    logic             alu_carry = 1'b0;
    logic             alu_ovf = 1'b0;
    logic             cond_valid = 1'b0;
    logic [3:0]       cond = 4'd0;
    logic             res_ready = 1'b1;

    logic       cond_ready_b, res_valid_b, res_taken_b;
    logic [3:0] flags_b;
    logic       cond_ready_n, res_valid_n, res_taken_n;
    logic [3:0] flags_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cond_flag_unit #(.WIDTH(WIDTH), .LATENCY(LAT), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .flags_we(flags_we), .alu_value(alu_value),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf), .cond_valid(cond_valid),
        .cond_ready(cond_ready_b), .cond(cond), .res_valid(res_valid_b),
        .res_ready(res_ready), .res_taken(res_taken_b), .flags(flags_b)
    );

    cond_flag_unit #(.WIDTH(WIDTH), .LATENCY(LAT), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .flags_we(flags_we), .alu_value(alu_value),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf), .cond_valid(cond_valid),
        .cond_ready(cond_ready_n), .cond(cond), .res_valid(res_valid_n),
        .res_ready(res_ready), .res_taken(res_taken_n), .flags(flags_n)
    );

    // Reference state per instance: index 0 bypasses, index 1 does not
    logic [3:0] m_flags [2];
    bit         m_v     [2][LAT];
    bit         m_t     [2][LAT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Codes 4-7 are inversions of 0-3; the upper half is V, C, C|Z and N with their inversions
    function automatic bit ref_eval(input logic [3:0] c, input logic [3:0] f);
        bit z  = f[0];
        bit n  = f[1];
        bit cy = f[2];
        bit v  = f[3];
        bit lt = (n != v);
        bit base;
        bit r;
        if (c < 8) begin
            case (c % 4)
                0:       base = 1'b0;
                1:       base = z;
                2:       base = lt;
                default: base = z || lt;
            endcase
            r = (c >= 4) ? !base : base;
        end else begin
            case (c)
                8:       r = v;
                9:       r = !v;
                10:      r = cy;
                11:      r = cy || z;
                12:      r = n;
                13:      r = !n;
                14:      r = !cy;
                default: r = !(cy || z);
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_flags(input logic [WIDTH-1:0] val, input bit c, input bit v);
        bit z = (val == 0);
        bit n = (val >= (1 << (WIDTH - 1)));
        return {v, c, n, z};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_flags[i] = 4'b0001;
            for (int s = 0; s < LAT; s++) begin
                m_v[i][s] = 1'b0;
                m_t[i][s] = 1'b0;
            end
        end
    endtask

    // Check current outputs against the reference, advance the reference, cross one edge
    task automatic step();
        logic [3:0] nf;
        logic [3:0] src;
        bit adv;
        #1;
        chk("ready_b", cond_ready_b, !m_v[0][LAT-1] || res_ready);
        chk("ready_n", cond_ready_n, !m_v[1][LAT-1] || res_ready);
        chk("valid_b", res_valid_b, m_v[0][LAT-1]);
        chk("valid_n", res_valid_n, m_v[1][LAT-1]);
        chk("flags_b", flags_b, m_flags[0]);
        chk("flags_n", flags_n, m_flags[1]);
        if (m_v[0][LAT-1]) chk("taken_b", res_taken_b, m_t[0][LAT-1]);
        if (m_v[1][LAT-1]) chk("taken_n", res_taken_n, m_t[1][LAT-1]);
        if (rst) begin
            model_reset();
        end else begin
            nf = ref_flags(alu_value, alu_carry, alu_ovf);
            for (int i = 0; i < 2; i++) begin
                src = (i == 0 && flags_we) ? nf : m_flags[i];
                adv = !m_v[i][LAT-1] || res_ready;
                if (flags_we) m_flags[i] = nf;
                if (adv) begin
                    for (int s = LAT - 1; s > 0; s--) begin
                        m_v[i][s] = m_v[i][s-1];
                        m_t[i][s] = m_t[i][s-1];
                    end
                    m_v[i][0] = cond_valid;
                    m_t[i][0] = ref_eval(cond, src);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] value;
        bit         carry;
        bit         ovf;
        logic [3:0] code;
        bit         exp_taken;
    } vec_t;

    vec_t vecs [20];
    int   delivered;

    initial begin
        vecs[0]  = '{8'h80, 0, 0, 4'd2,  1};
        vecs[1]  = '{8'h80, 0, 0, 4'd3,  1};
        vecs[2]  = '{8'h80, 0, 0, 4'd6,  0};
        vecs[3]  = '{8'h80, 0, 0, 4'd7,  0};
        vecs[4]  = '{8'h80, 0, 0, 4'd12, 1};
        vecs[5]  = '{8'h05, 1, 0, 4'd10, 1};
        vecs[6]  = '{8'h05, 1, 0, 4'd11, 1};
        vecs[7]  = '{8'h05, 1, 0, 4'd14, 0};
        vecs[8]  = '{8'h05, 1, 0, 4'd15, 0};
        vecs[9]  = '{8'h00, 0, 0, 4'd10, 0};
        vecs[10] = '{8'h00, 0, 0, 4'd11, 1};
        vecs[11] = '{8'h00, 0, 0, 4'd15, 0};
        vecs[12] = '{8'h00, 0, 0, 4'd1,  1};
        vecs[13] = '{8'h00, 0, 0, 4'd5,  0};
        vecs[14] = '{8'h7F, 0, 1, 4'd2,  1};
        vecs[15] = '{8'h7F, 0, 1, 4'd8,  1};
        vecs[16] = '{8'h7F, 0, 1, 4'd9,  0};
        vecs[17] = '{8'h7F, 0, 1, 4'd6,  0};
        vecs[18] = '{8'h7F, 0, 1, 4'd4,  1};
        vecs[19] = '{8'h7F, 0, 1, 4'd13, 1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Reset state and first request
        chk("rst_flags", flags_b, 4'b0001);
        chk("rst_valid", res_valid_b, 1'b0);
        chk("rst_taken", res_taken_b, 1'b0);
        chk("rst_ready", cond_ready_b, 1'b1);
        cond_valid = 1'b1; cond = 4'd1;
        step();
        cond_valid = 1'b0;
        chk("lat_early", res_valid_b, 1'b0);
        step();
        chk("lat_valid", res_valid_b, 1'b1);
        chk("eq_reset", res_taken_b, 1'b1);
        step();

        // Table of flag settings and expected outcomes
        foreach (vecs[i]) begin
            flags_we = 1'b1; alu_value = vecs[i].value;
            alu_carry = vecs[i].carry; alu_ovf = vecs[i].ovf;
            step();
            flags_we = 1'b0; cond_valid = 1'b1; cond = vecs[i].code;
            step();
            cond_valid = 1'b0;
            step();
            chk($sformatf("vec%0d_valid", i), res_valid_b, 1'b1);
            chk($sformatf("vec%0d_taken", i), res_taken_b, vecs[i].exp_taken);
            step();
        end
        chk("flags_after_tbl", flags_b, 4'b1000);

        // Same-cycle capture and request: bypass vs stored flags
        flags_we = 1'b1; alu_value = 8'h01; alu_carry = 1'b0; alu_ovf = 1'b0;
        step();
        alu_value = 8'h00; cond_valid = 1'b1; cond = 4'd5;
        step();
        flags_we = 1'b0; cond_valid = 1'b0;
        step();
        chk("byp_valid", res_valid_b && res_valid_n, 1'b1);
        chk("byp_on_ne", res_taken_b, 1'b0);
        chk("byp_off_ne", res_taken_n, 1'b1);
        step();

        // Back-to-back requests with a three-cycle consumer stall (stored Z=1)
        delivered = 0;
        cond_valid = 1'b1; cond = 4'd1; step();
        cond = 4'd5; step();
        chk("b2b_first", res_valid_b, 1'b1);
        chk("b2b_first_t", res_taken_b, 1'b1);
        cond = 4'd5; res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", cond_ready_b, 1'b0);
            chk("stall_taken", res_taken_b, 1'b1);
            step();
        end
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) cond = 4'd4;
            if (k == 2) cond_valid = 1'b0;
            #1;
            if (res_valid_b) delivered++;
            step();
        end
        chk("b2b_count", delivered, 4);

        // Reset with results in flight
        flags_we = 1'b1; alu_value = 8'h80; step();
        flags_we = 1'b0; cond_valid = 1'b1; cond = 4'd4; step();
        step();
        chk("inflight", res_valid_b, 1'b1);
        rst = 1'b1; flags_we = 1'b1; alu_value = 8'h11;
        step();
        rst = 1'b0; flags_we = 1'b0; cond_valid = 1'b0;
        chk("rst_mid_valid", res_valid_b, 1'b0);
        chk("rst_mid_flags", flags_b, 4'b0001);
        cond_valid = 1'b1; cond = 4'd1; step();
        cond_valid = 1'b0; step();
        chk("post_rst_valid", res_valid_b, 1'b1);
        chk("post_rst_taken", res_taken_b, 1'b1);
        step();

        // Randomized traffic against the reference
        for (int k = 0; k < 500; k++) begin
            rst        = ($urandom_range(63) == 0);
            flags_we   = ($urandom_range(2) == 0);
            alu_value  = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            alu_carry  = 1'($urandom);
            alu_ovf    = 1'($urandom);
            cond_valid = ($urandom_range(9) < 7);
            cond       = 4'($urandom);
            res_ready  = ($urandom_range(3) != 0);
            step();
        end
        rst = 1'b0; cond_valid = 1'b0; flags_we = 1'b0; res_ready = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
